// File: rtl/deferred_update_wheel_pkg.sv
// Shared types and helpers for the deferred update wheel.
// The slot struct depends on WIDTH, so it is declared inside the top module.
package deferred_update_pkg;

  typedef enum logic {
    LAST_WINS  = 1'b0,
    FIRST_WINS = 1'b1
  } policy_e;

  // Slot index ptr+d modulo n; d never exceeds n, so one subtraction is enough.
  function automatic int unsigned wrap_add(input int unsigned ptr, input int unsigned d,
                                           input int unsigned n);
    int unsigned s;
    s = ptr + d;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/deferred_update_wheel_if.sv
// Request/response bundle for the deferred update wheel.
// The master side issues schedule requests; the slave side is the wheel.
interface deferred_update_wheel_if #(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned MAX_DELAY = 16
);
  localparam int unsigned DW = $clog2(MAX_DELAY + 1);

  logic                         policy;
  logic [NUM_CH-1:0]            req_valid;
  logic [NUM_CH-1:0][DW-1:0]    req_delay;
  logic [NUM_CH-1:0][WIDTH-1:0] req_data;
  logic [NUM_CH-1:0]            req_err;
  logic [NUM_CH-1:0]            req_lost;
  logic [WIDTH-1:0]             out_q;
  logic                         out_event;
  logic                         out_change;
  logic [DW-1:0]                pend_cnt;

  modport master (
    output policy, req_valid, req_delay, req_data,
    input  req_err, req_lost, out_q, out_event, out_change, pend_cnt
  );

  modport slave (
    input  policy, req_valid, req_delay, req_data,
    output req_err, req_lost, out_q, out_event, out_change, pend_cnt
  );
endinterface

// File: rtl/deferred_update_wheel_arb.sv
// Combinational per-slot arbitration of the schedule requests.
// Highest channel index wins a slot; FIRST_WINS protects an already pending slot.
module deferred_update_arb
  import deferred_update_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned MAX_DELAY = 16,
  localparam int unsigned DW = $clog2(MAX_DELAY + 1),
  localparam int unsigned PW = $clog2(MAX_DELAY),
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          policy,
  input  logic [NUM_CH-1:0]             req_valid,
  input  logic [NUM_CH-1:0][DW-1:0]     req_delay,
  input  logic [PW-1:0]                 ptr,
  input  logic [MAX_DELAY-1:0]          slot_valid,
  output logic [MAX_DELAY-1:0]          slot_we,
  output logic [MAX_DELAY-1:0][CW-1:0]  slot_sel,
  output logic [NUM_CH-1:0]             req_err,
  output logic [NUM_CH-1:0]             req_lost
);

  logic [NUM_CH-1:0]         live;
  logic [NUM_CH-1:0][PW-1:0] target;

  always_comb begin
    live    = '0;
    req_err = '0;
    target  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      live[c]    = req_valid[c] && (req_delay[c] != '0) && (req_delay[c] <= DW'(MAX_DELAY));
      req_err[c] = req_valid[c] && !live[c];
      target[c]  = PW'(wrap_add(32'(ptr), 32'(req_delay[c]), MAX_DELAY));
    end
  end

  always_comb begin
    logic hit;
    logic keep;
    slot_we  = '0;
    slot_sel = '0;
    for (int s = 0; s < MAX_DELAY; s++) begin
      hit = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (live[c] && (target[c] == PW'(s))) begin
          hit         = 1'b1;
          slot_sel[s] = CW'(c);
        end
      end
      // The slot under ptr is being applied now, so it never counts as pending.
      keep       = (policy_e'(policy) == FIRST_WINS) && slot_valid[s] && (PW'(s) != ptr);
      slot_we[s] = hit && !keep;
    end
  end

  always_comb begin
    req_lost = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      req_lost[c] = live[c] &&
                    ((slot_sel[target[c]] != CW'(c)) || !slot_we[target[c]]);
    end
  end

endmodule

// File: rtl/deferred_update_wheel.sv
// Clocked timing wheel that applies per-channel updates a fixed number of cycles later.
// Slot storage, pointer, output register and all status pulses are registered here.
module deferred_update_wheel
  import deferred_update_pkg::*;
#(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      NUM_CH    = 2,
  parameter int unsigned      MAX_DELAY = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                    clk,
  input logic                    rst_n,
  deferred_update_wheel_if.slave bus
);

  localparam int unsigned DW = $clog2(MAX_DELAY + 1);
  localparam int unsigned PW = $clog2(MAX_DELAY);
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } slot_t;

  slot_t [MAX_DELAY-1:0]         slots_q, slots_d;
  logic  [PW-1:0]                ptr_q, ptr_d;
  logic  [WIDTH-1:0]             val_q, val_d;
  logic                          event_q, event_d;
  logic                          change_q, change_d;
  logic  [NUM_CH-1:0]            err_q, err_d;
  logic  [NUM_CH-1:0]            lost_q, lost_d;
  logic  [DW-1:0]                cnt_q, cnt_d;
  logic  [MAX_DELAY-1:0]         slot_valid;
  logic  [MAX_DELAY-1:0]         slot_we;
  logic  [MAX_DELAY-1:0][CW-1:0] slot_sel;

  always_comb begin
    for (int s = 0; s < MAX_DELAY; s++) slot_valid[s] = slots_q[s].valid;
  end

  deferred_update_arb #(
    .NUM_CH    (NUM_CH),
    .MAX_DELAY (MAX_DELAY)
  ) u_arb (
    .policy     (bus.policy),
    .req_valid  (bus.req_valid),
    .req_delay  (bus.req_delay),
    .ptr        (ptr_q),
    .slot_valid (slot_valid),
    .slot_we    (slot_we),
    .slot_sel   (slot_sel),
    .req_err    (err_d),
    .req_lost   (lost_d)
  );

  always_comb begin
    slots_d  = slots_q;
    val_d    = val_q;
    event_d  = 1'b0;
    change_d = 1'b0;
    if (slots_q[ptr_q].valid) begin
      val_d                 = slots_q[ptr_q].data;
      event_d               = 1'b1;
      change_d              = (slots_q[ptr_q].data != val_q);
      slots_d[ptr_q].valid  = 1'b0;
    end
    // Writes come after the apply-clear so a full-wheel delay refills the slot just applied.
    for (int s = 0; s < MAX_DELAY; s++) begin
      if (slot_we[s]) begin
        slots_d[s].valid = 1'b1;
        slots_d[s].data  = bus.req_data[slot_sel[s]];
      end
    end
    cnt_d = '0;
    for (int s = 0; s < MAX_DELAY; s++) cnt_d = cnt_d + DW'(slots_d[s].valid);
    ptr_d = (ptr_q == PW'(MAX_DELAY - 1)) ? '0 : ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_q  <= '0;
      ptr_q    <= '0;
      val_q    <= RESET_VAL;
      event_q  <= 1'b0;
      change_q <= 1'b0;
      err_q    <= '0;
      lost_q   <= '0;
      cnt_q    <= '0;
    end else begin
      slots_q  <= slots_d;
      ptr_q    <= ptr_d;
      val_q    <= val_d;
      event_q  <= event_d;
      change_q <= change_d;
      err_q    <= err_d;
      lost_q   <= lost_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.out_q      = val_q;
  assign bus.out_event  = event_q;
  assign bus.out_change = change_q;
  assign bus.req_err    = err_q;
  assign bus.req_lost   = lost_q;
  assign bus.pend_cnt   = cnt_q;

endmodule

// File: tb/tb_deferred_update_wheel.sv
// Self-checking bench for deferred_update_wheel: directed scenarios plus random traffic
// compared against a due-time queue model.
module tb_deferred_update_wheel;
  import deferred_update_pkg::*;

  localparam int unsigned      WIDTH     = 4;
  localparam int unsigned      NUM_CH    = 3;
  localparam int unsigned      MAX_DELAY = 16;
  localparam int unsigned      DW        = $clog2(MAX_DELAY + 1);
  localparam logic [WIDTH-1:0] RESET_VAL = 4'hA;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  deferred_update_wheel_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .MAX_DELAY(MAX_DELAY)) bus ();

  deferred_update_wheel #(
    .WIDTH     (WIDTH),
    .NUM_CH    (NUM_CH),
    .MAX_DELAY (MAX_DELAY),
    .RESET_VAL (RESET_VAL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: pending updates keyed by absolute due cycle.
  typedef struct {
    int               due;
    logic [WIDTH-1:0] data;
  } entry_t;
  entry_t            pending[$];
  int                now = 0;
  logic [WIDTH-1:0]  m_out;
  logic              m_event, m_change;
  logic [NUM_CH-1:0] m_err, m_lost;

  function automatic void model_reset();
    pending.delete();
    m_out = RESET_VAL;
    m_event = 1'b0;
    m_change = 1'b0;
    m_err = '0;
    m_lost = '0;
  endfunction

  function automatic void model_edge();
    int hit;
    m_event = 1'b0;
    m_change = 1'b0;
    m_err = '0;
    m_lost = '0;
    hit = -1;
    for (int i = 0; i < pending.size(); i++) if (pending[i].due == now) hit = i;
    if (hit >= 0) begin
      m_event = 1'b1;
      m_change = (pending[hit].data != m_out);
      m_out = pending[hit].data;
      pending.delete(hit);
    end
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      int d;
      bit beaten;
      int k;
      if (!bus.req_valid[c]) continue;
      d = int'(bus.req_delay[c]);
      if (d < 1 || d > int'(MAX_DELAY)) begin
        m_err[c] = 1'b1;
        continue;
      end
      beaten = 1'b0;
      for (int c2 = c + 1; c2 < NUM_CH; c2++)
        if (bus.req_valid[c2] && bus.req_delay[c2] == bus.req_delay[c]) beaten = 1'b1;
      if (beaten) begin
        m_lost[c] = 1'b1;
        continue;
      end
      k = -1;
      for (int i = 0; i < pending.size(); i++) if (pending[i].due == now + d) k = i;
      if (k >= 0) begin
        if (bus.policy) m_lost[c] = 1'b1;
        else pending[k].data = bus.req_data[c];
      end else begin
        pending.push_back('{due: now + d, data: bus.req_data[c]});
      end
    end
    now++;
  endfunction

  task automatic clear_req();
    bus.req_valid = '0;
    bus.req_delay = '0;
    bus.req_data  = '0;
  endtask

  task automatic set_req(input int c, input int d, input logic [WIDTH-1:0] v);
    bus.req_valid[c] = 1'b1;
    bus.req_delay[c] = DW'(d);
    bus.req_data[c]  = v;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.policy = LAST_WINS;
    clear_req();
    model_reset();
    #12;
    checks++;
    if ({bus.out_q, bus.out_event, bus.pend_cnt} !== {RESET_VAL, 1'b0, DW'(0)}) begin
      failures++;
      $display("FAIL reset_hold: got out=%0h ev=%0b pend=%0d want out=%0h ev=0 pend=0",
               bus.out_q, bus.out_event, bus.pend_cnt, RESET_VAL);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({bus.out_q, bus.out_event, bus.out_change, bus.req_err, bus.req_lost, bus.pend_cnt}
          !== {RESET_VAL, 1'b0, 1'b0, 3'b000, 3'b000, DW'(0)}) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: got out=%0h ev=%0b ch=%0b err=%b lost=%b pend=%0d",
                 i, bus.out_q, bus.out_event, bus.out_change, bus.req_err, bus.req_lost,
                 bus.pend_cnt);
      end
    end
  endtask

  task automatic test_single();
    set_req(0, 10, 4'h1);
    tick();
    clear_req();
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (bus.pend_cnt !== DW'(1) || bus.out_event !== 1'b0) begin
        failures++;
        $display("FAIL single_wait +%0d: got pend=%0d ev=%0b want pend=1 ev=0",
                 j, bus.pend_cnt, bus.out_event);
      end
      tick();
    end
    checks++;
    if ({bus.out_q, bus.out_event, bus.out_change, bus.pend_cnt} !== {4'h1, 1'b1, 1'b1, DW'(0)}) begin
      failures++;
      $display("FAIL single_apply: got out=%0h ev=%0b ch=%0b pend=%0d want 1 1 1 0",
               bus.out_q, bus.out_event, bus.out_change, bus.pend_cnt);
    end
    tick();
    checks++;
    if (bus.out_event !== 1'b0 || bus.out_change !== 1'b0) begin
      failures++;
      $display("FAIL single_pulse_width: got ev=%0b ch=%0b want 0 0", bus.out_event,
               bus.out_change);
    end
  endtask

  task automatic test_same_cycle(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
    set_req(0, 10, d0);
    set_req(1, 10, d1);
    tick();
    clear_req();
    checks++;
    if (bus.req_lost !== 3'b001) begin
      failures++;
      $display("FAIL same_cycle_lost: got %b want 001", bus.req_lost);
    end
    tick();
    checks++;
    if (bus.req_lost !== 3'b000) begin
      failures++;
      $display("FAIL same_cycle_lost_clear: got %b want 000", bus.req_lost);
    end
    repeat (8) tick();
    tick();
    checks++;
    if (bus.out_q !== d1 || bus.out_event !== 1'b1) begin
      failures++;
      $display("FAIL same_cycle_apply: got out=%0h ev=%0b want out=%0h ev=1",
               bus.out_q, bus.out_event, d1);
    end
  endtask

  task automatic test_pending_conflict(input logic pol, input logic [WIDTH-1:0] want_out,
                                       input logic [NUM_CH-1:0] want_lost);
    bus.policy = pol;
    set_req(0, 10, 4'h3);
    tick();
    clear_req();
    repeat (2) tick();
    set_req(1, 7, 4'hC);
    tick();
    clear_req();
    checks++;
    if (bus.req_lost !== want_lost) begin
      failures++;
      $display("FAIL pending_lost pol=%0b: got %b want %b", pol, bus.req_lost, want_lost);
    end
    repeat (6) tick();
    tick();
    checks++;
    if (bus.out_q !== want_out || bus.out_event !== 1'b1) begin
      failures++;
      $display("FAIL pending_apply pol=%0b: got out=%0h ev=%0b want out=%0h ev=1",
               pol, bus.out_q, bus.out_event, want_out);
    end
    bus.policy = LAST_WINS;
  endtask

  task automatic test_max_delay();
    bit saw_event;
    set_req(0, 5, 4'h7);
    tick();
    clear_req();
    repeat (4) tick();
    set_req(1, MAX_DELAY, 4'h9);
    tick();
    clear_req();
    checks++;
    if ({bus.out_q, bus.out_event, bus.pend_cnt, bus.req_lost} !== {4'h7, 1'b1, DW'(1), 3'b000}) begin
      failures++;
      $display("FAIL max_delay_old: got out=%0h ev=%0b pend=%0d lost=%b want 7 1 1 000",
               bus.out_q, bus.out_event, bus.pend_cnt, bus.req_lost);
    end
    saw_event = 1'b0;
    repeat (15) begin
      tick();
      if (bus.out_event) saw_event = 1'b1;
    end
    checks++;
    if (saw_event !== 1'b0) begin
      failures++;
      $display("FAIL max_delay_early: got early event=1 want 0");
    end
    tick();
    checks++;
    if ({bus.out_q, bus.out_event, bus.pend_cnt} !== {4'h9, 1'b1, DW'(0)}) begin
      failures++;
      $display("FAIL max_delay_new: got out=%0h ev=%0b pend=%0d want 9 1 0",
               bus.out_q, bus.out_event, bus.pend_cnt);
    end
    set_req(0, 0, 4'hF);
    set_req(1, MAX_DELAY + 1, 4'hE);
    tick();
    clear_req();
    checks++;
    if ({bus.req_err, bus.req_lost, bus.pend_cnt} !== {3'b011, 3'b000, DW'(0)}) begin
      failures++;
      $display("FAIL illegal_delay: got err=%b lost=%b pend=%0d want 011 000 0",
               bus.req_err, bus.req_lost, bus.pend_cnt);
    end
    saw_event = 1'b0;
    repeat (MAX_DELAY + 2) begin
      tick();
      if (bus.out_event) saw_event = 1'b1;
    end
    checks++;
    if (saw_event !== 1'b0 || bus.out_q !== 4'h9 || bus.req_err !== 3'b000) begin
      failures++;
      $display("FAIL illegal_no_effect: got ev_seen=%0b out=%0h err=%b want 0 9 000",
               saw_event, bus.out_q, bus.req_err);
    end
  endtask

  task automatic test_async_reset();
    bit saw_event;
    for (int i = 0; i < 5; i++) begin
      set_req(0, 12, WIDTH'(i + 1));
      tick();
      clear_req();
    end
    checks++;
    if (bus.pend_cnt !== DW'(5)) begin
      failures++;
      $display("FAIL async_pre_pend: got %0d want 5", bus.pend_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({bus.out_q, bus.pend_cnt, bus.out_event} !== {RESET_VAL, DW'(0), 1'b0}) begin
      failures++;
      $display("FAIL async_immediate: got out=%0h pend=%0d ev=%0b want %0h 0 0",
               bus.out_q, bus.pend_cnt, bus.out_event, RESET_VAL);
    end
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    saw_event = 1'b0;
    repeat (20) begin
      tick();
      if (bus.out_event || bus.out_q !== RESET_VAL) saw_event = 1'b1;
    end
    checks++;
    if (saw_event !== 1'b0 || bus.pend_cnt !== DW'(0)) begin
      failures++;
      $display("FAIL async_after_release: got stray=%0b pend=%0d want 0 0",
               saw_event, bus.pend_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clear_req();
      bus.policy = logic'($urandom_range(0, 1));
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 2) == 0)
          set_req(c, int'($urandom_range(0, MAX_DELAY + 3)), WIDTH'($urandom));
      tick();
      checks++;
      if (bus.out_q !== m_out || bus.out_event !== m_event || bus.out_change !== m_change) begin
        failures++;
        $display("FAIL rand_out %0d: got out=%0h ev=%0b ch=%0b want out=%0h ev=%0b ch=%0b",
                 i, bus.out_q, bus.out_event, bus.out_change, m_out, m_event, m_change);
      end
      checks++;
      if (bus.req_err !== m_err || bus.req_lost !== m_lost) begin
        failures++;
        $display("FAIL rand_req %0d: got err=%b lost=%b want err=%b lost=%b",
                 i, bus.req_err, bus.req_lost, m_err, m_lost);
      end
      checks++;
      if (bus.pend_cnt !== DW'(pending.size())) begin
        failures++;
        $display("FAIL rand_pend %0d: got %0d want %0d", i, bus.pend_cnt, pending.size());
      end
    end
    clear_req();
    bus.policy = LAST_WINS;
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_cycle(4'h0, 4'h1);
    test_same_cycle(4'h1, 4'h0);
    test_pending_conflict(1'b0, 4'hC, 3'b000);
    test_pending_conflict(1'b1, 4'h3, 3'b010);
    test_max_delay();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
